rolling_avg_mc: RTL and testbench

Multi-channel rolling-average engine, the parametrised successor to the single-channel 8×5-bit averager. It accepts samples tagged with a channel number on a slow, asynchronous data strobe and keeps an independent window per channel. It supports simple moving average (SMA) or exponential moving average (EMA), and publishes a registered average with a valid pulse. It sits behind the io_in pin mux of the top-level wrapper, in the same position as its predecessor.

---
 rtl/rolling_avg_pkg.sv | 17 +
 rtl/rolling_avg_mc_strobe_sync.sv | 20 ++
 rtl/rolling_avg_mc.sv | 122 ++++++++++++
 tb/tb_rolling_avg_mc.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/rolling_avg_pkg.sv
// Shared types and width helpers for the multi-channel rolling averager.
package rolling_avg_pkg;

  typedef enum logic {
    MODE_SMA = 1'b0,
    MODE_EMA = 1'b1
  } mode_e;

  function automatic int sum_w(input int bits, input int log2_depth);
    return bits + log2_depth;
  endfunction

  function automatic int chan_w(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/rolling_avg_mc_strobe_sync.sv
// Two-flop synchroniser for the slow sample strobe plus a history flop;
// emits a single-cycle pulse per synchronised rising edge.
module strobe_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic strobe,
  output logic event_pulse
);

  // sh[1:0] synchronise, sh[2] remembers the previous synchronised level
  logic [2:0] sh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sh <= '0;
    else        sh <= {sh[1:0], strobe};
  end

  assign event_pulse = sh[1] & ~sh[2];

endmodule

// File: rtl/rolling_avg_mc.sv
// Multi-channel SMA/EMA rolling averager fed by an asynchronous sample strobe.
// Update happens in the event cycle; the average is published one cycle later.
module rolling_avg_mc
  import rolling_avg_pkg::*;
#(
  parameter int CHANNELS      = 2,
  parameter int BITS_PER_ELEM = 5,
  parameter int LOG2_DEPTH    = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_data_clk,
  input  logic [chan_w(CHANNELS)-1:0]   i_chan,
  input  logic [BITS_PER_ELEM-1:0]      i_value,
  input  logic                          i_clear,
  input  logic                          i_mode,
  output logic [BITS_PER_ELEM-1:0]      o_avg,
  output logic [chan_w(CHANNELS)-1:0]   o_chan,
  output logic                          o_valid,
  output logic                          o_full
);

  localparam int CW    = chan_w(CHANNELS);
  localparam int SUM_W = sum_w(BITS_PER_ELEM, LOG2_DEPTH);
  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam int FW    = LOG2_DEPTH + 1;

  logic ev;

  strobe_sync u_sync (
    .clk         (clk),
    .rst_n       (rst),
    .strobe      (i_data_clk),
    .event_pulse (ev)
  );

  mode_e                  mode;
  logic [SUM_W-1:0]       sum_q  [CHANNELS];
  logic [LOG2_DEPTH-1:0]  wptr_q [CHANNELS];
  logic [FW-1:0]          fill_q [CHANNELS];
  logic [BITS_PER_ELEM-1:0] buf_q [CHANNELS][DEPTH];

  // vld_pipe[0]: update done, publish pending; vld_pipe[1]: o_valid
  logic [1:0]    vld_pipe;
  logic [CW-1:0] pub_chan;

  logic            chan_ok, accept, is_full;
  logic [CW-1:0]   ci;
  logic [SUM_W-1:0] cur_sum, old_val, x_ext, nxt_sum;

  assign chan_ok = int'(i_chan) < CHANNELS;
  assign ci      = chan_ok ? i_chan : '0;
  assign accept  = ev & chan_ok & ~i_clear;

  always_comb begin
    cur_sum = sum_q[ci];
    is_full = (fill_q[ci] == FW'(DEPTH));
    x_ext   = SUM_W'(i_value);
    // buffer slots are only trusted once the window has wrapped
    old_val = is_full ? SUM_W'(buf_q[ci][wptr_q[ci]]) : '0;
    if (mode == MODE_EMA) nxt_sum = cur_sum - (cur_sum >> LOG2_DEPTH) + x_ext;
    else                  nxt_sum = cur_sum - old_val + x_ext;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode        <= MODE_SMA;
      vld_pipe[0] <= 1'b0;
      pub_chan    <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        sum_q[c]  <= '0;
        wptr_q[c] <= '0;
        fill_q[c] <= '0;
      end
    end else if (i_clear) begin
      mode        <= mode_e'(i_mode);
      vld_pipe[0] <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        sum_q[c]  <= '0;
        wptr_q[c] <= '0;
        fill_q[c] <= '0;
      end
    end else begin
      vld_pipe[0] <= accept;
      if (accept) begin
        pub_chan   <= ci;
        sum_q[ci]  <= nxt_sum;
        wptr_q[ci] <= wptr_q[ci] + 1'b1;
        if (!is_full) fill_q[ci] <= fill_q[ci] + 1'b1;
      end
    end
  end

  // Sample storage carries no reset; stale entries are masked by the fill count.
  always_ff @(posedge clk) begin
    if (accept) buf_q[ci][wptr_q[ci]] <= i_value;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_pipe[1] <= 1'b0;
      o_avg       <= '0;
      o_chan      <= '0;
      o_full      <= 1'b0;
    end else if (i_clear) begin
      vld_pipe[1] <= 1'b0;
      o_avg       <= '0;
      o_chan      <= '0;
      o_full      <= 1'b0;
    end else begin
      vld_pipe[1] <= vld_pipe[0];
      if (vld_pipe[0]) begin
        o_avg  <= sum_q[pub_chan][SUM_W-1:LOG2_DEPTH];
        o_chan <= pub_chan;
        o_full <= (fill_q[pub_chan] == FW'(DEPTH));
      end
    end
  end

  assign o_valid = vld_pipe[1];

endmodule

// File: tb/tb_rolling_avg_mc.sv
// Directed scoreboard bench for rolling_avg_mc (2-channel main DUT, 3-channel side DUT).
module tb_rolling_avg_mc;

  typedef struct {
    int avg;
    int chan;
    int full;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       strobe = 1'b0, i_clear = 1'b0, i_mode = 1'b0;
  logic [0:0] i_chan = '0;
  logic [4:0] i_value = '0;
  logic [4:0] o_avg;
  logic [0:0] o_chan;
  logic       o_valid, o_full;

  logic       strobe3 = 1'b0, clear3 = 1'b0, mode3 = 1'b0;
  logic [1:0] chan3 = '0;
  logic [4:0] value3 = '0;
  logic [4:0] o_avg3;
  logic [1:0] o_chan3;
  logic       o_valid3, o_full3;

  int n_tests = 0;
  int n_fail  = 0;

  exp_t q0[$];
  exp_t q3[$];

  int m_sum[2], m_wp[2], m_fill[2];
  int m_buf[2][8];
  bit m_ema;

  always #5 clk = ~clk;

  rolling_avg_mc #(.CHANNELS(2), .BITS_PER_ELEM(5), .LOG2_DEPTH(3)) u_dut (
    .clk(clk), .rst(rst), .i_data_clk(strobe), .i_chan(i_chan), .i_value(i_value),
    .i_clear(i_clear), .i_mode(i_mode), .o_avg(o_avg), .o_chan(o_chan),
    .o_valid(o_valid), .o_full(o_full)
  );

  rolling_avg_mc #(.CHANNELS(3), .BITS_PER_ELEM(5), .LOG2_DEPTH(3)) u_dut3 (
    .clk(clk), .rst(rst), .i_data_clk(strobe3), .i_chan(chan3), .i_value(value3),
    .i_clear(clear3), .i_mode(mode3), .o_avg(o_avg3), .o_chan(o_chan3),
    .o_valid(o_valid3), .o_full(o_full3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void model_clear(input bit ema);
    for (int c = 0; c < 2; c++) begin
      m_sum[c] = 0; m_wp[c] = 0; m_fill[c] = 0;
    end
    m_ema = ema;
  endfunction

  function automatic exp_t model_step(input int ch, input int x);
    exp_t e;
    int old;
    old = (m_fill[ch] == 8) ? m_buf[ch][m_wp[ch]] : 0;
    if (m_ema) m_sum[ch] = m_sum[ch] - (m_sum[ch] >> 3) + x;
    else       m_sum[ch] = m_sum[ch] - old + x;
    m_buf[ch][m_wp[ch]] = x;
    m_wp[ch] = (m_wp[ch] + 1) % 8;
    if (m_fill[ch] < 8) m_fill[ch]++;
    e.avg = m_sum[ch] >> 3; e.chan = ch; e.full = (m_fill[ch] == 8) ? 1 : 0;
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (o_valid === 1'b1) begin
      if (q0.size() == 0) chk("unexpected_valid", o_valid, 0);
      else begin
        e = q0.pop_front();
        chk("avg", o_avg, e.avg);
        chk("chan", o_chan, e.chan);
        chk("full", o_full, e.full);
      end
    end
    if (o_valid3 === 1'b1) begin
      if (q3.size() == 0) chk("unexpected_valid3", o_valid3, 0);
      else begin
        e = q3.pop_front();
        chk("avg3", o_avg3, e.avg);
        chk("chan3", o_chan3, e.chan);
        chk("full3", o_full3, e.full);
      end
    end
  end

  task automatic send(input int ch, input int v);
    @(negedge clk);
    i_chan = 1'(ch); i_value = 5'(v); strobe = 1'b1;
    q0.push_back(model_step(ch, v));
    repeat (4) @(posedge clk);
    @(negedge clk) strobe = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  task automatic send3(input int ch, input int v);
    @(negedge clk);
    chan3 = 2'(ch); value3 = 5'(v); strobe3 = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk) strobe3 = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  task automatic do_clear(input bit mode);
    @(negedge clk);
    i_clear = 1'b1; i_mode = mode;
    @(negedge clk);
    i_clear = 1'b0;
    model_clear(mode);
    chk("clr_avg", o_avg, 0);
    chk("clr_chan", o_chan, 0);
    chk("clr_full", o_full, 0);
  endtask

  task automatic drain(input string tag);
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk(tag, q0.size(), 0);
  endtask

  initial begin
    exp_t e;
    model_clear(1'b0);

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_avg", o_avg, 0);
    chk("rst_chan", o_chan, 0);
    chk("rst_valid", o_valid, 0);
    chk("rst_full", o_full, 0);
    rst = 1'b1;
    repeat (2) @(posedge clk);

    // SMA on ch0: 8 x 31 then a 0
    for (int i = 0; i < 8; i++) send(0, 31);
    send(0, 0);
    drain("sma_drain");

    // interleaved channels
    do_clear(1'b0);
    for (int i = 0; i < 8; i++) begin
      send(0, 16);
      send(1, 8);
    end
    drain("interleave_drain");

    // EMA on ch0
    do_clear(1'b1);
    for (int i = 0; i < 3; i++) send(0, 31);
    drain("ema_drain");

    // clear in the event cycle drops the event
    do_clear(1'b0);
    send(0, 12);
    void'(q0.pop_back());
    model_clear(1'b0);
    @(negedge clk);
    i_chan = 1'b1; i_value = 5'd20; strobe = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk) i_clear = 1'b1; i_mode = 1'b0;
    @(negedge clk) i_clear = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) strobe = 1'b0;
    drain("clrE_no_valid");
    chk("clrE_avg", o_avg, 0);
    send(0, 8);
    drain("clrE_next");

    // strobe held high 20 cycles: one event, published at E+2
    @(negedge clk);
    i_chan = 1'b1; i_value = 5'd24; strobe = 1'b1;
    q0.push_back(model_step(1, 24));
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("hold_before", o_valid, 0);
    @(posedge clk);
    @(negedge clk);
    chk("hold_at_e2", o_valid, 1);
    repeat (16) @(posedge clk);
    @(negedge clk) strobe = 1'b0;
    drain("hold_one_valid");

    // rst in E+1: publish suppressed; release with strobe high gives one event
    @(negedge clk);
    i_chan = 1'b0; i_value = 5'd20; strobe = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    chk("rstp_valid", o_valid, 0);
    chk("rstp_avg", o_avg, 0);
    chk("rstp_chan", o_chan, 0);
    chk("rstp_full", o_full, 0);
    model_clear(1'b0);
    e = model_step(0, 20);
    q0.push_back(e);
    @(negedge clk) rst = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk) strobe = 1'b0;
    drain("rst_release_event");

    // 3-channel DUT: out-of-range channel ignored
    send3(3, 31);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("oor_avg3", o_avg3, 0);
    e.avg = 3; e.chan = 2; e.full = 0;
    q3.push_back(e);
    send3(2, 24);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("ch3_drain", q3.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
